imm_gen_pipe: RTL

- Parametrised, pipelined successor to the decode-stage immediate generator.
- Extracts and sign/zero-extends RISC-V immediates for XLEN 32 or 64, including CSR-zimm and shift-amount forms.
- Has an AUTO mode that selects the format from the opcode.
- Sits between fetch and decode/execute behind a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

---
 rtl/imm_gen_pipe.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extractor (XLEN 32/64, AUTO opcode decode); optional sideband tag via IMM_GEN_TAG_EN.
// Latency: 1 cycle, registered outputs only; 2-entry skid (M/K) keeps order, never drops or duplicates.
// Backpressure: in_ready is registered and deasserts only when the skid entry K is occupied.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [2:0]        imm_type,
`ifdef IMM_GEN_TAG_EN
    input  logic [TAG_W-1:0]  in_tag,
    output logic [TAG_W-1:0]  out_tag,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   immediate,
    output logic              fmt_err
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("imm_gen_pipe: TAG_W must be at least 1");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef enum logic [3:0] {F_U, F_J, F_I, F_B, F_S, F_Z, F_SH, F_SH5, F_NONE} fmt_t;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic [XLEN-1:0]   m_imm_q, k_imm_q;
    logic              m_err_q, k_err_q;
    logic              m_load, m_from_k, k_load, accept;
    fmt_t              fmt;
    logic [31:0]       raw32;
    logic              sext;
    logic [XLEN-1:0]   new_imm;
    logic              new_err;

    // Format selection; AUTO resolves from the opcode and funct3.
    always_comb begin
        fmt = F_NONE;
        unique case (imm_type)
            3'b000: fmt = F_U;
            3'b001: fmt = F_J;
            3'b010: fmt = F_I;
            3'b011: fmt = F_B;
            3'b100: fmt = F_S;
            3'b101: fmt = F_Z;
            3'b110: fmt = F_SH;
            default: begin
                case (inst[6:0])
                    7'b0110111, 7'b0010111: fmt = F_U;
                    7'b1101111:             fmt = F_J;
                    7'b1100111, 7'b0000011: fmt = F_I;
                    7'b1100011:             fmt = F_B;
                    7'b0100011:             fmt = F_S;
                    7'b0010011: fmt = (inst[13:12] == 2'b01) ? F_SH  : F_I;
                    7'b0011011: fmt = (inst[13:12] == 2'b01) ? F_SH5 : F_I;
                    7'b1110011: fmt = inst[14] ? F_Z : F_I;
                    default:    fmt = F_NONE;
                endcase
            end
        endcase
    end

    always_comb begin
        raw32 = '0;
        sext  = 1'b1;
        case (fmt)
            F_U:   raw32 = {inst[31:12], 12'b0};
            F_J:   raw32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            F_I:   raw32 = {{20{inst[31]}}, inst[31:20]};
            F_B:   raw32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            F_S:   raw32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            F_Z:   begin sext = 1'b0; raw32 = {27'b0, inst[19:15]}; end
            F_SH:  begin sext = 1'b0; raw32 = {26'b0, (XLEN == 64) && inst[25], inst[24:20]}; end
            F_SH5: begin sext = 1'b0; raw32 = {27'b0, inst[24:20]}; end
            default: begin sext = 1'b0; raw32 = '0; end
        endcase
        new_imm = XLEN'(raw32);
        // Upper mask is empty when XLEN is 32.
        if (sext && raw32[31]) new_imm = new_imm | ~XLEN'(32'hFFFF_FFFF);
        new_err = (fmt == F_NONE);
    end

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_from_k = 1'b0;
        k_load   = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                m_load  = 1'b1;
            end
            ONE: begin
                if (accept && out_ready) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    k_load  = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (out_ready) begin
                state_d  = ONE;
                m_load   = 1'b1;
                m_from_k = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_imm_q    <= '0;
            m_err_q    <= 1'b0;
            k_imm_q    <= '0;
            k_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (m_load) begin
                m_imm_q <= m_from_k ? k_imm_q : new_imm;
                m_err_q <= m_from_k ? k_err_q : new_err;
            end
            if (k_load) begin
                k_imm_q <= new_imm;
                k_err_q <= new_err;
            end
        end
    end

`ifdef IMM_GEN_TAG_EN
    logic [TAG_W-1:0] m_tag_q, k_tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_tag_q <= '0;
            k_tag_q <= '0;
        end else begin
            if (m_load) m_tag_q <= m_from_k ? k_tag_q : in_tag;
            if (k_load) k_tag_q <= in_tag;
        end
    end

    assign out_tag = m_tag_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign immediate = m_imm_q;
    assign fmt_err   = m_err_q;

endmodule
